// File: rtl/fence_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fence_sequencer_pkg
// Shared types for the fence-class sequencer: operation type, FSM state
// encoding, and helpers used by the sequencer and the commit stage.
//   fence_type_t   : FENCE / FENCE.I / SFENCE.VMA
//   fence_state_t  : sequencer FSM states
//   to_fence_type  : maps the raw 2-bit request code (3 = reserved -> FENCE)
//   fence_cnt_width: width of the I$ flush cycle counter (minimum 1 bit)
// -----------------------------------------------------------------------------
package fence_sequencer_pkg;

  typedef enum logic [1:0] {
    FENCE_T      = 2'd0,
    FENCE_I_T    = 2'd1,
    SFENCE_VMA_T = 2'd2
  } fence_type_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_DFLUSH = 3'd2,
    S_IFLUSH = 3'd3,
    S_TLB    = 3'd4,
    S_DONE   = 3'd5
  } fence_state_t;

  // The reserved code 3 is executed as a plain FENCE.
  function automatic fence_type_t to_fence_type(input logic [1:0] op);
    fence_type_t t;
    case (op)
      2'd1:    t = FENCE_I_T;
      2'd2:    t = SFENCE_VMA_T;
      default: t = FENCE_T;
    endcase
    return t;
  endfunction

  function automatic int unsigned fence_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/fence_sequencer.sv
// -----------------------------------------------------------------------------
// fence_sequencer
// Multi-cycle controller for FENCE, FENCE.I and SFENCE.VMA retired on commit
// port 0. Sequence: drain store buffer -> flush D$ -> flush I$ -> flush TLBs
// -> flush pipeline / done. Commit holds the instruction un-acked until done_o.
//
// Handshake: a request is accepted in a cycle where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE, not in the
// cycle right after DONE, and not while halt_i is high. Once accepted, a
// sequence always completes; req_valid_i and halt_i are ignored outside IDLE.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_valid_i/type_i     fence-class request from commit port 0
//   req_ready_o            sequencer can accept
//   halt_i                 core halt, blocks acceptance
//   no_st_pending_i        store buffer empty
//   dcache_flush_o/ack_i   D$ flush level request / 1-cycle completion pulse
//   icache_flush_o         I$ flush, held ICACHE_FLUSH_CYCLES cycles
//   tlb_flush_o            ITLB/DTLB flush, 1 cycle
//   flush_pipeline_o       frontend/issue flush, 1 cycle (with done_o)
//   done_o                 sequence complete, commit acks this cycle
//   busy_o                 not idle
//   dbg_state_o            current FSM state
// -----------------------------------------------------------------------------
module fence_sequencer
  import fence_sequencer_pkg::*;
#(
  parameter int unsigned ICACHE_FLUSH_CYCLES  = 4,
  parameter bit          FENCE_FLUSHES_DCACHE = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  input  logic [1:0]   req_type_i,
  output logic         req_ready_o,
  input  logic         halt_i,
  input  logic         no_st_pending_i,
  output logic         dcache_flush_o,
  input  logic         dcache_flush_ack_i,
  output logic         icache_flush_o,
  output logic         tlb_flush_o,
  output logic         flush_pipeline_o,
  output logic         done_o,
  output logic         busy_o,
  output fence_state_t dbg_state_o
);

  localparam int unsigned     CNT_W    = fence_cnt_width(ICACHE_FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ICACHE_FLUSH_CYCLES - 1);

  fence_state_t     r_state;
  fence_type_t      r_type;
  logic [CNT_W-1:0] r_cnt;
  logic             r_just_done;
  logic             r_dflush;
  logic             r_iflush;
  logic             r_tlb;
  logic             r_done;
  logic             r_busy;

  fence_state_t     w_next_state;
  logic             w_accept;

  // halt_i is the only input that reaches an output: it gates acceptance in
  // the same cycle so a halting core never sees a fence taken.
  assign req_ready_o = (r_state == S_IDLE) && !r_just_done && !halt_i;
  assign w_accept    = req_valid_i && req_ready_o;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (no_st_pending_i) begin
          case (r_type)
            FENCE_I_T:    w_next_state = S_DFLUSH;
            SFENCE_VMA_T: w_next_state = S_TLB;
            default:      w_next_state = FENCE_FLUSHES_DCACHE ? S_DFLUSH : S_DONE;
          endcase
        end
      end
      S_DFLUSH: begin
        if (dcache_flush_ack_i) begin
          w_next_state = (r_type == FENCE_I_T) ? S_IFLUSH : S_DONE;
        end
      end
      S_IFLUSH: begin
        if (r_cnt == '0) w_next_state = S_DONE;
      end
      S_TLB:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_type      <= FENCE_T;
      r_cnt       <= '0;
      r_just_done <= 1'b0;
      r_dflush    <= 1'b0;
      r_iflush    <= 1'b0;
      r_tlb       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Commit may still present the retiring fence one cycle after DONE.
      r_just_done <= (r_state == S_DONE);
      if (w_accept) r_type <= to_fence_type(req_type_i);

      // Loaded with N-1 so IFLUSH lasts exactly N cycles (exit on zero).
      if ((r_state == S_DFLUSH) && (w_next_state == S_IFLUSH)) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == S_IFLUSH) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      r_dflush <= (w_next_state == S_DFLUSH);
      r_iflush <= (w_next_state == S_IFLUSH);
      r_tlb    <= (w_next_state == S_TLB);
      r_done   <= (w_next_state == S_DONE);
      r_busy   <= (w_next_state != S_IDLE);
    end
  end

  assign dcache_flush_o   = r_dflush;
  assign icache_flush_o   = r_iflush;
  assign tlb_flush_o      = r_tlb;
  assign flush_pipeline_o = r_done;
  assign done_o           = r_done;
  assign busy_o           = r_busy;
  assign dbg_state_o      = r_state;

endmodule
